logic_op_sequencer: RTL

Sequential front/back end for the combinational bitwise logic unit in the BinaryLogic step. Accepts two operands over a single narrow valid/ready input stream, presents them as stable registered operands to the logic unit, captures the unit's result one cycle later, and holds it on a valid/ready output until consumed. Also counts completed operations and flags an all-ones result, which for the XNOR unit means the two operands were equal.

---
 rtl/logic_op_sequencer_pkg.sv | 16 +
 rtl/logic_op_sequencer_if.sv | 37 +++
 rtl/logic_op_sequencer.sv | 147 ++++++++++++++
 3 files changed

// File: rtl/logic_op_sequencer_pkg.sv
// Shared definitions for the logic-op sequencer: FSM state encoding and
// default datapath widths.
package logic_seq_pkg;

  localparam int unsigned DEF_WIDTH = 32'd4;
  localparam int unsigned DEF_CNT_W = 32'd8;

  // Operation phases: collect A, collect B, let the logic unit settle, hold result.
  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    EXEC   = 2'd2,
    HOLD   = 2'd3
  } seq_state_e;

endpackage

// File: rtl/logic_op_sequencer_if.sv
// Operand input stream and result output stream of the logic-op sequencer.
// The sequencer uses the slave view; the producer/consumer uses the master view.
interface logic_op_sequencer_if
  import logic_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
);

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_allones;

  modport slave (
    input  in_valid,
    input  in_data,
    input  out_ready,
    output in_ready,
    output out_valid,
    output out_data,
    output out_allones
  );

  modport master (
    output in_valid,
    output in_data,
    output out_ready,
    input  in_ready,
    input  out_valid,
    input  out_data,
    input  out_allones
  );

endinterface

// File: rtl/logic_op_sequencer.sv
// Front/back end for an external combinational bitwise logic unit: collects
// two operand beats, presents them as registered operands, captures the unit's
// result after one settle cycle and holds it until consumed. Counts completed
// operations and flags an all-ones result.
module logic_op_sequencer
  import logic_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  logic_op_sequencer_if.slave  bus,
  output logic [WIDTH-1:0]     op_a,
  output logic [WIDTH-1:0]     op_b,
  input  logic [WIDTH-1:0]     lu_result,
  output logic                 busy,
  output logic [CNT_W-1:0]     op_count
);

  seq_state_e       state_r;
  seq_state_e       state_nxt_s;
  logic [WIDTH-1:0] op_a_r;
  logic [WIDTH-1:0] op_b_r;
  logic [WIDTH-1:0] out_data_r;
  logic             out_allones_r;
  logic [CNT_W-1:0] op_count_r;

  logic             in_ready_s;
  logic             out_valid_s;
  logic             busy_s;
  logic             load_a_s;
  logic             load_b_s;
  logic             capture_s;
  logic             consume_s;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= LOAD_A;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic; clear overrides every transition.
  always_comb begin
    state_nxt_s = state_r;
    if (clear) begin
      state_nxt_s = LOAD_A;
    end else begin
      case (state_r)
        LOAD_A: begin
          if (bus.in_valid) state_nxt_s = LOAD_B;
          else              state_nxt_s = LOAD_A;
        end
        LOAD_B: begin
          if (bus.in_valid) state_nxt_s = EXEC;
          else              state_nxt_s = LOAD_B;
        end
        EXEC: begin
          state_nxt_s = HOLD;
        end
        HOLD: begin
          if (bus.out_ready) state_nxt_s = LOAD_A;
          else               state_nxt_s = HOLD;
        end
        default: begin
          state_nxt_s = LOAD_A;
        end
      endcase
    end
  end

  // Handshake/status outputs decoded purely from the state register.
  always_comb begin
    in_ready_s  = 1'b0;
    out_valid_s = 1'b0;
    busy_s      = 1'b0;
    case (state_r)
      LOAD_A: begin
        in_ready_s = 1'b1;
      end
      LOAD_B: begin
        in_ready_s = 1'b1;
        busy_s     = 1'b1;
      end
      EXEC: begin
        busy_s = 1'b1;
      end
      HOLD: begin
        out_valid_s = 1'b1;
        busy_s      = 1'b1;
      end
      default: begin
        in_ready_s = 1'b0;
      end
    endcase
  end

  // Datapath enables; a beat or consume coinciding with clear is dropped.
  always_comb begin
    load_a_s  = 1'b0;
    load_b_s  = 1'b0;
    capture_s = 1'b0;
    consume_s = 1'b0;
    if (!clear) begin
      load_a_s  = (state_r == LOAD_A) && bus.in_valid;
      load_b_s  = (state_r == LOAD_B) && bus.in_valid;
      capture_s = (state_r == EXEC);
      consume_s = (state_r == HOLD) && bus.out_ready;
    end else begin
      load_a_s = 1'b0;
    end
  end

  // Operand, result and completion-counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a_r        <= {WIDTH{1'b0}};
      op_b_r        <= {WIDTH{1'b0}};
      out_data_r    <= {WIDTH{1'b0}};
      out_allones_r <= 1'b0;
      op_count_r    <= {CNT_W{1'b0}};
    end else begin
      if (load_a_s) op_a_r <= bus.in_data;
      if (load_b_s) op_b_r <= bus.in_data;
      if (capture_s) begin
        out_data_r    <= lu_result;
        out_allones_r <= &lu_result;
      end
      // Counter wraps silently at 2^CNT_W.
      if (consume_s) op_count_r <= op_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign op_a            = op_a_r;
  assign op_b            = op_b_r;
  assign op_count        = op_count_r;
  assign busy            = busy_s;
  assign bus.in_ready    = in_ready_s;
  assign bus.out_valid   = out_valid_s;
  assign bus.out_data    = out_data_r;
  assign bus.out_allones = out_allones_r;

endmodule
